// File: rtl/lut_pkg.sv
// Shared types for the branch-target lookup table: controller state and the
// packed {relative, target} entry layout used by the default configuration.
package lut_pkg;

  localparam int LUT_TARGET_W = 10;

  typedef enum logic {
    INIT,
    READY
  } lut_state_t;

  typedef struct packed {
    logic                    relative;
    logic [LUT_TARGET_W-1:0] target;
  } lut_entry_t;

endpackage

// File: rtl/lut_init_seq.sv
// Init sweep for the lookup table: walks an index over every entry once,
// strobing a write per cycle, then raises done until restarted.
module lut_init_seq #(
  parameter int ADDR_W = 2
) (
  input  logic              Clk_i,
  input  logic              Reset_n_i,
  input  logic              restart_i,
  output logic [ADDR_W-1:0] index_o,
  output logic              wr_o,
  output logic              done_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] index_q, index_d;
  logic              done_q, done_d;

  always_comb begin
    index_d = index_q;
    done_d  = done_q;
    if (restart_i) begin
      index_d = '0;
      done_d  = 1'b0;
    end else if (!done_q) begin
      index_d = index_q + IDX_ONE;
      if (index_q == LAST_IDX) begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      index_q <= '0;
      done_q  <= 1'b0;
    end else begin
      index_q <= index_d;
      done_q  <= done_d;
    end
  end

  assign index_o = index_q;
  assign wr_o    = !done_q;
  assign done_o  = done_q;

endmodule

// File: rtl/branch_target_lut.sv
// Writable branch-target table for fetch: registered lookups with write-first
// bypass, hardware init after reset or Clear, runtime rewrite port.
module branch_target_lut
  import lut_pkg::*;
#(
  parameter int ADDR_W         = 2,
  parameter int TARGET_W       = 10,
  parameter int DEFAULT_TARGET = 1
) (
  input  logic                Clk_i,
  input  logic                Reset_n_i,
  input  logic                Clear_i,
  input  logic                RdEn_i,
  input  logic [ADDR_W-1:0]   RdAddr_i,
  output logic [TARGET_W-1:0] Target_o,
  output logic                Relative_o,
  output logic                TargetValid_o,
  input  logic                WrEn_i,
  input  logic [ADDR_W-1:0]   WrAddr_i,
  input  logic [TARGET_W-1:0] WrData_i,
  input  logic                WrRelative_i,
  output logic                WrReady_o,
  output logic                Busy_o
);

  localparam int                  DEPTH       = 2**ADDR_W;
  localparam logic [ADDR_W-1:0]   LAST_IDX    = ADDR_W'(DEPTH-1);
  localparam logic [TARGET_W-1:0] INIT_TARGET = TARGET_W'(DEFAULT_TARGET);

  lut_state_t state_q, state_d;

  logic [ADDR_W-1:0]   initIdx;
  logic                initWr;
  logic                initDone;

  logic [TARGET_W:0]   entries_q [DEPTH];

  logic [TARGET_W-1:0] target_q, target_d;
  logic                relative_q, relative_d;
  logic                valid_q, valid_d;

  logic                live;
  logic                restart;
  logic                wrAccept;
  logic                bypass;

  lut_init_seq #(
    .ADDR_W (ADDR_W)
  ) u_init_seq (
    .Clk_i     (Clk_i),
    .Reset_n_i (Reset_n_i),
    .restart_i (restart),
    .index_o   (initIdx),
    .wr_o      (initWr),
    .done_o    (initDone)
  );

  // Clear beats a same-cycle write; the dropped write must not feed the bypass.
  assign live     = (state_q == READY) && initDone;
  assign restart  = live && Clear_i;
  assign wrAccept = live && WrEn_i && !Clear_i;
  assign bypass   = wrAccept && (WrAddr_i == RdAddr_i);

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (initWr && (initIdx == LAST_IDX)) state_d = READY;
      READY:   if (Clear_i) state_d = INIT;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    target_d   = target_q;
    relative_d = relative_q;
    valid_d    = 1'b0;
    if (live && RdEn_i) begin
      valid_d = 1'b1;
      if (bypass) begin
        {relative_d, target_d} = {WrRelative_i, WrData_i};
      end else begin
        {relative_d, target_d} = entries_q[RdAddr_i];
      end
    end
  end

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state_q    <= INIT;
      target_q   <= '0;
      relative_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      relative_q <= relative_d;
      valid_q    <= valid_d;
    end
  end

  // Storage has no reset; the init sweep is the only thing that defines it.
  always_ff @(posedge Clk_i) begin
    if ((state_q == INIT) && initWr) begin
      entries_q[initIdx] <= {1'b1, INIT_TARGET};
    end else if (wrAccept) begin
      entries_q[WrAddr_i] <= {WrRelative_i, WrData_i};
    end
  end

  assign Target_o      = target_q;
  assign Relative_o    = relative_q;
  assign TargetValid_o = valid_q;
  assign WrReady_o     = (state_q == READY);
  assign Busy_o        = (state_q == INIT);

endmodule

// File: tb/tb_branch_target_lut.sv
// Scoreboard bench for branch_target_lut: reads push expected entries, a
// negedge monitor pops and compares whenever TargetValid is presented.
module tb_branch_target_lut;
  import lut_pkg::*;

  localparam int ADDR_W   = 2;
  localparam int TARGET_W = 10;

  logic                Clk = 1'b0;
  logic                Reset_n;
  logic                Clear;
  logic                RdEn;
  logic [ADDR_W-1:0]   RdAddr;
  logic [TARGET_W-1:0] Target;
  logic                Relative;
  logic                TargetValid;
  logic                WrEn;
  logic [ADDR_W-1:0]   WrAddr;
  logic [TARGET_W-1:0] WrData;
  logic                WrRelative;
  logic                WrReady;
  logic                Busy;

  lut_entry_t expQ[$];
  int compared   = 0;
  int mismatched = 0;

  branch_target_lut #(
    .ADDR_W         (ADDR_W),
    .TARGET_W       (TARGET_W),
    .DEFAULT_TARGET (1)
  ) dut (
    .Clk_i         (Clk),
    .Reset_n_i     (Reset_n),
    .Clear_i       (Clear),
    .RdEn_i        (RdEn),
    .RdAddr_i      (RdAddr),
    .Target_o      (Target),
    .Relative_o    (Relative),
    .TargetValid_o (TargetValid),
    .WrEn_i        (WrEn),
    .WrAddr_i      (WrAddr),
    .WrData_i      (WrData),
    .WrRelative_i  (WrRelative),
    .WrReady_o     (WrReady),
    .Busy_o        (Busy)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every presented lookup must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    lut_entry_t e;
    if (TargetValid === 1'b1) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected TargetValid: got 1, expected 0");
      end else begin
        e = expQ.pop_front();
        checkOutput("lookup target", 32'(Target), 32'(e.target));
        checkOutput("lookup relative", 32'(Relative), 32'(e.relative));
      end
    end
  end

  task automatic applyStimulus(input logic rd, input logic [ADDR_W-1:0] rdA,
                               input logic wr, input logic [ADDR_W-1:0] wrA,
                               input logic [TARGET_W-1:0] wrD, input logic wrRel,
                               input logic clr);
    RdEn = rd; RdAddr = rdA;
    WrEn = wr; WrAddr = wrA; WrData = wrD; WrRelative = wrRel;
    Clear = clr;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic expectEntry(input logic rel, input logic [TARGET_W-1:0] tgt);
    lut_entry_t e;
    e.relative = rel;
    e.target   = tgt;
    expQ.push_back(e);
  endtask

  task automatic readEntry(input logic [ADDR_W-1:0] a, input logic rel, input logic [TARGET_W-1:0] tgt);
    expectEntry(rel, tgt);
    applyStimulus(1'b1, a, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic checkBusyLen(input string name);
    int n;
    n = 0;
    while (Busy && n < 20) begin
      @(posedge Clk);
      #1;
      n++;
    end
    checkOutput(name, 32'(n), 32'd4);
    checkOutput({name, " wrready"}, 32'(WrReady), 32'd1);
  endtask

  initial begin
    int n;
    Reset_n = 1'b0;
    Clear = 1'b0; RdEn = 1'b0; RdAddr = '0;
    WrEn = 1'b0; WrAddr = '0; WrData = '0; WrRelative = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    checkOutput("reset busy", 32'(Busy), 32'd1);
    checkOutput("reset wrready", 32'(WrReady), 32'd0);
    checkOutput("reset valid", 32'(TargetValid), 32'd0);
    checkOutput("reset target", 32'(Target), 32'd0);
    checkOutput("reset relative", 32'(Relative), 32'd0);

    // Release and hammer the ports during init; everything must be ignored.
    Reset_n = 1'b1;
    n = 0;
    while (Busy && n < 20) begin
      applyStimulus(1'b1, n[1:0], 1'b1, n[1:0], 10'h2aa, 1'b0, (n == 1));
      n++;
      checkOutput("valid during init", 32'(TargetValid), 32'd0);
    end
    RdEn = 1'b0; WrEn = 1'b0; Clear = 1'b0;
    checkOutput("init busy cycles", 32'(n), 32'd4);
    checkOutput("init wrready", 32'(WrReady), 32'd1);

    for (int a = 0; a < 4; a++) readEntry(2'(a), 1'b1, 10'h001);
    idle();

    applyStimulus(1'b0, '0, 1'b1, 2'd0, 10'h3f0, 1'b1, 1'b0);
    readEntry(2'd0, 1'b1, 10'h3f0);

    // Same-address bypass, then different-address independence.
    expectEntry(1'b0, 10'h007);
    applyStimulus(1'b1, 2'd2, 1'b1, 2'd2, 10'h007, 1'b0, 1'b0);
    readEntry(2'd2, 1'b0, 10'h007);
    expectEntry(1'b1, 10'h001);
    applyStimulus(1'b1, 2'd1, 1'b1, 2'd3, 10'h155, 1'b0, 1'b0);
    readEntry(2'd3, 1'b0, 10'h155);
    idle();

    // Clear drops the concurrent write but the concurrent read sees old data.
    applyStimulus(1'b0, '0, 1'b1, 2'd1, 10'h003, 1'b0, 1'b0);
    expectEntry(1'b0, 10'h003);
    applyStimulus(1'b1, 2'd1, 1'b1, 2'd3, 10'h055, 1'b0, 1'b1);
    RdEn = 1'b0; WrEn = 1'b0; Clear = 1'b0;
    checkOutput("clear busy", 32'(Busy), 32'd1);
    checkBusyLen("clear busy cycles");
    readEntry(2'd1, 1'b1, 10'h001);
    readEntry(2'd3, 1'b1, 10'h001);
    readEntry(2'd0, 1'b1, 10'h001);
    idle();

    // Reset asserted with the init index at 2.
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1);
    idle();
    idle();
    Reset_n = 1'b0;
    #1;
    checkOutput("midinit reset busy", 32'(Busy), 32'd1);
    checkOutput("midinit reset wrready", 32'(WrReady), 32'd0);
    checkOutput("midinit reset target", 32'(Target), 32'd0);
    checkOutput("midinit reset relative", 32'(Relative), 32'd0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    checkBusyLen("reinit busy cycles");
    readEntry(2'd2, 1'b1, 10'h001);
    readEntry(2'd0, 1'b1, 10'h001);
    idle();
    idle();

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
